// File: rtl/inv_shift_rows_pipe_pkg.sv
// Shared AES helpers for the InvShiftRows pipeline stage.
//   AES_STATE_W   : width of one AES state block.
//   byte_msb()    : top bit of byte (column c, row r) in a column-major
//                   state, where byte 0 sits at [127:120].
//   INV_SR_SRC    : InvShiftRows permutation. Output byte k is taken from
//                   input byte INV_SR_SRC[k], with byte index 4*column+row.
//   buf_state_e   : occupancy state of the 2-entry output buffer.
package inv_shift_rows_pipe_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  // Row r of the output is row r of the input rotated right by r columns,
  // so output (c, r) reads input ((c - r) mod 4, r).
  localparam int INV_SR_SRC [AES_BYTES] = '{
     0, 13, 10,  7,
     4,  1, 14, 11,
     8,  5,  2, 15,
    12,  9,  6,  3
  };

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  function automatic int byte_msb(input int col, input int row);
    return AES_STATE_W - 1 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/inv_shift_rows_comb.sv
// Purely combinational InvShiftRows byte permutation.
//   state_in  : AES state, column-major, byte 0 = [127:120]
//   state_out : InvShiftRows(state_in)
module inv_shift_rows_comb
  import inv_shift_rows_pipe_pkg::*;
(
  input  logic [AES_STATE_W-1:0] state_in,
  output logic [AES_STATE_W-1:0] state_out
);

  for (genvar k = 0; k < AES_BYTES; k++) begin : g_byte
    assign state_out[byte_msb(k / 4, k % 4) -: 8] =
      state_in[byte_msb(INV_SR_SRC[k] / 4, INV_SR_SRC[k] % 4) -: 8];
  end

endmodule

// File: rtl/inv_shift_rows_pipe.sv
// Elastic InvShiftRows stage with a 2-entry output buffer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous clear of buffered blocks and counter
//   in_valid/in_ready     : upstream handshake
//   in_state/in_tag       : incoming AES state and sideband tag
//   out_valid/out_ready   : downstream handshake
//   out_state/out_tag     : head entry (already transformed) and its tag
//   blk_count             : blocks accepted since reset/flush, wrapping
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on the registered occupancy, never on
// out_ready, so no combinational path crosses the stage. out_* stay stable
// while out_valid is high and out_ready is low.
module inv_shift_rows_pipe
  import inv_shift_rows_pipe_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic [TAG_W-1:0]       out_tag,
  output logic [CNT_W-1:0]       blk_count
);

  logic [AES_STATE_W-1:0] shifted;
  logic [AES_STATE_W-1:0] data_mem [2];
  logic [TAG_W-1:0]       tag_mem  [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic                   accept;
  logic                   pop;
  buf_state_e             state_q;
  buf_state_e             state_d;

  // Transform on the write path so the buffer holds finished data.
  inv_shift_rows_comb u_comb (
    .state_in  (in_state),
    .state_out (shifted)
  );

  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_state = data_mem[rd_ptr];
  assign out_tag   = tag_mem[rd_ptr];

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next-state; flush overrides any accept/pop in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: if (accept)        state_d = BUF_ONE;
        BUF_ONE: begin
          if (accept && !pop)         state_d = BUF_FULL;
          else if (pop && !accept)    state_d = BUF_EMPTY;
        end
        BUF_FULL:  if (pop)           state_d = BUF_ONE;
        default:                      state_d = BUF_EMPTY;
      endcase
    end
  end

  // Pointers and accepted-block counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      blk_count <= '0;
    end else if (flush) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      blk_count <= '0;
    end else begin
      if (accept) begin
        wr_ptr    <= ~wr_ptr;
        blk_count <= blk_count + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Storage; cleared on reset so the outputs read zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else if (accept && !flush) begin
      data_mem[wr_ptr] <= shifted;
      tag_mem[wr_ptr]  <= in_tag;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_pipe.sv
module tb_inv_shift_rows_pipe;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int W     = 128 + TAG_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [127:0]       in_state = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [127:0]       out_state;
  logic [TAG_W-1:0]   out_tag;
  logic [CNT_W-1:0]   blk_count;

  inv_shift_rows_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_tag   (out_tag),
    .blk_count (blk_count)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: out byte(c,r) = in byte((c-r) mod 4, r), byte k at [127-8k -: 8].
  function automatic logic [127:0] ref_inv_sr(input logic [127:0] s);
    logic [7:0] b [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) b[k] = s[127 - 8*k -: 8];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = b[4*((c - r + 4) % 4) + r];
    return o;
  endfunction

  task automatic check_outputs(input string tag);
    logic [W-1:0] head;
    check({tag, ".out_valid"}, out_valid, (exp_q.size() != 0));
    check({tag, ".in_ready"},  in_ready,  (exp_q.size() != 2));
    check({tag, ".blk_count"}, blk_count, exp_cnt);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check({tag, ".out_state"}, out_state, head[W-1 -: 128]);
      check({tag, ".out_tag"},   out_tag,   head[TAG_W-1:0]);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, predict the edge, then check outputs.
  task automatic cycle(input logic v, input logic [127:0] st, input logic [TAG_W-1:0] tg,
                       input logic rdy, input logic fl, input string tag);
    logic acc, pp;
    in_valid  = v;
    in_state  = st;
    in_tag    = tg;
    out_ready = rdy;
    flush     = fl;
    acc = v && (exp_q.size() < 2) && !fl;
    pp  = rdy && (exp_q.size() > 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({ref_inv_sr(st), tg});
        exp_cnt = exp_cnt + 1'b1;
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] r;
    logic [127:0] held;
    int outs;

    do_reset();
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.in_ready",  in_ready,  1'b1);
    check("reset.blk_count", blk_count, '0);
    check("reset.out_state", out_state, '0);

    // Basic transform, constant expectation.
    cycle(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 4'd3, 1'b0, 1'b0, "basic");
    check("basic.const_state", out_state, 128'h000d0a07_04010e0b_0805020f_0c090603);
    check("basic.const_tag",   out_tag,   4'd3);
    check("basic.const_cnt",   blk_count, 4'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "drain1");

    // Round trip from forward-shifted pattern.
    cycle(1'b1, 128'h00050a0f_04090e03_080d0207_0c01060b, 4'd5, 1'b0, 1'b0, "roundtrip");
    check("roundtrip.const", out_state, 128'h000102030405060708090a0b0c0d0e0f);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "drain2");

    // Backpressure: three offers with out_ready low, third must be held.
    for (int t = 1; t <= 3; t++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, r, TAG_W'(t), 1'b0, 1'b0, "bp_fill");
    end
    check("bp.in_ready_low", in_ready, 1'b0);
    held = out_state;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, "bp_stall");
    check("bp.stable", out_state, held);
    check("bp.head_tag1", out_tag, 4'd1);
    for (int t = 0; t < 3; t++) cycle(1'b0, '0, '0, 1'b1, 1'b0, "bp_drain");

    // Streaming: 16 back-to-back random blocks, no bubbles.
    do_reset();
    outs = 0;
    for (int t = 0; t < 16; t++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, r, TAG_W'($urandom_range(0, 15)), 1'b1, 1'b0, "stream");
      if (out_valid) outs++;
    end
    check("stream.outputs", outs, 16);
    // CNT_W=4: 16 accepts from reset wrap the counter to zero.
    check("wrap.blk_count", blk_count, 4'd0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "stream_drain");

    // Random mixed traffic.
    for (int t = 0; t < 60; t++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), r, TAG_W'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b0, "random");
    end

    // Fill two entries, then flush with a simultaneous offer and pop.
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "pre_flush");
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "pre_flush");
    for (int t = 0; t < 2; t++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, r, TAG_W'(t + 7), 1'b0, 1'b0, "flush_fill");
    end
    cycle(1'b1, 128'h1, 4'd9, 1'b1, 1'b1, "flush");
    check("flush.out_valid", out_valid, 1'b0);
    check("flush.in_ready",  in_ready,  1'b1);
    check("flush.blk_count", blk_count, 4'd0);

    // Asynchronous reset between edges with two blocks buffered.
    for (int t = 0; t < 2; t++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, r, TAG_W'(t + 2), 1'b0, 1'b0, "arst_fill");
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", out_valid, 1'b0);
    check("arst.out_state", out_state, '0);
    check("arst.out_tag",   out_tag,   '0);
    check("arst.in_ready",  in_ready,  1'b1);
    check("arst.blk_count", blk_count, '0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    r = {$urandom, $urandom, $urandom, $urandom};
    cycle(1'b1, r, 4'd12, 1'b0, 1'b0, "post_arst");
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "post_arst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
